// File: rtl/mul_seq32.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier.
// One partial-product step per clock through an adder that lives outside this block.
module mul_seq32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   add_a,
   output logic [WIDTH-1:0]   add_b,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic               add_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_count;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_p_hi;
   logic [WIDTH-1:0]   r_p_lo;
   logic               w_accept;
   logic               w_last;
   logic [2*WIDTH-1:0] w_shift;

   // 65-bit {cout, sum, P_lo} shifted right by one; the dropped LSB is P_lo[0].
   assign w_shift = {add_cout, add_sum, r_p_lo[WIDTH-1:1]};

   assign add_a   = r_p_hi;
   assign add_b   = r_p_lo[0] ? r_mcand : '0;
   assign product = {r_p_hi, r_p_lo};
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = (r_count == CNT_W'(WIDTH-1));
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // The edge leaving RUN still performs the final iteration.
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_mcand <= '0;
         r_p_hi  <= '0;
         r_p_lo  <= '0;
      end else if (w_accept) begin
         r_count <= '0;
         r_mcand <= mcand;
         r_p_hi  <= '0;
         r_p_lo  <= mplier;
      end else if (r_state == S_RUN) begin
         {r_p_hi, r_p_lo} <= w_shift;
         r_count          <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mul_seq32.sv
// Directed bench for mul_seq32 with a behavioural model of the external adder.
module tb_mul_seq32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] mcand = '0;
   logic [31:0] mplier = '0;
   logic        busy, done;
   logic [63:0] product;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_cout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   mul_seq32 #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product),
      .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      int lat;
      bit seen;
      lat  = 0;
      seen = 1'b0;
      @(negedge clk);
      mcand = a; mplier = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mcand = ~a; mplier = ~b;
      chk("busy_after_accept", 64'(busy), 64'd1);
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(posedge clk); #1;
         if (b == 32'd0 && busy) chk("zero_add_b", 64'(add_b), 64'd0);
         if (done) begin
            seen = 1'b1;
            lat  = k;
         end
      end
      if (!seen) begin
         chk("done_timeout", 64'd0, 64'd1);
      end else begin
         chk("latency", 64'(lat), 64'd32);
         chk("busy_with_done", 64'(busy), 64'd1);
         chk("product", product, exp);
         @(posedge clk); #1;
         chk("done_one_cycle", 64'(done), 64'd0);
         chk("busy_after_done", 64'(busy), 64'd0);
         repeat (3) @(posedge clk);
         #1 chk("product_hold", product, exp);
      end
   endtask

   initial begin
      int ndone;
      int t1, t2;
      logic [63:0] p1, p2;
      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{32'h1234_5678,  32'd0,          64'd0};
      vecs[3] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
      vecs[4] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
      vecs[5] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
      vecs[6] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
      vecs[7] = '{32'd0,          32'hDEAD_BEEF,  64'd0};
      vecs[8] = '{32'h0001_0001,  32'h0000_FFFF,  64'h0000_0000_FFFF_FFFF};

      #1 rst = 1'b1;
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_add_a", 64'(add_a), 64'd0);
      chk("rst_add_b", 64'(add_b), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 9; i++) run_mul(vecs[i].a, vecs[i].b, vecs[i].exp);

      // start held high: one done per 34-cycle period, operands changed mid-run
      ndone = 0; t1 = 0; t2 = 0; p1 = '0; p2 = '0;
      @(negedge clk);
      mcand = 32'd7; mplier = 32'd6; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 67; k++) begin
         @(posedge clk); #1;
         if (k == 10) begin mcand = 32'd9; mplier = 32'd9; end
         if (done) begin
            ndone++;
            if (ndone == 1) begin t1 = k; p1 = product; end
            if (ndone == 2) begin t2 = k; p2 = product; end
         end
      end
      start = 1'b0;
      chk("hold_start_count", 64'(ndone), 64'd2);
      chk("hold_start_t1", 64'(t1), 64'd32);
      chk("hold_start_t2", 64'(t2), 64'd66);
      chk("hold_start_p1", p1, 64'd42);
      chk("hold_start_p2", p2, 64'd81);
      repeat (2) @(posedge clk);

      // asynchronous reset in the middle of a run
      @(negedge clk);
      mcand = 32'h10; mplier = 32'h10; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_product", product, 64'd0);
      @(negedge clk) rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done || busy) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);
      run_mul(32'd2, 32'd2, 64'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
